// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: one digit per slot, a dark interval
// at each slot start, a per-frame input snapshot and optional leading-zero blanking.
module seg_scan_ctrl #(
    parameter int N_DIGITS   = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 500,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [4*N_DIGITS-1:0]       digits_in,
    input  logic [N_DIGITS-1:0]         dp_in,
    input  logic                        lz_suppress,
    output logic [N_DIGITS-1:0]         an,
    output logic [6:0]                  seg,
    output logic                        dp,
    output logic [$clog2(N_DIGITS)-1:0] digit_idx,
    output logic                        frame_tick
);

    localparam int   IDX_W      = $clog2(N_DIGITS);
    localparam int   CNT_W      = $clog2(SCAN_DIV);
    localparam int   BLANK_LAST = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;
    localparam logic POL        = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_t;

    // A slot opens dark unless there is no blank interval at all.
    localparam state_t SLOT_START = (BLANK_CYC == 0) ? SHOW : BLANK;

    state_t                state_q;
    logic [CNT_W-1:0]      slot_cnt_q;
    logic [IDX_W-1:0]      digit_idx_q;
    logic [4*N_DIGITS-1:0] snap_digits_q;
    logic [N_DIGITS-1:0]   snap_dp_q;
    logic                  snap_lz_q;
    logic [N_DIGITS-1:0]   an_q;
    logic [6:0]            seg_q;
    logic                  dp_q;
    logic                  frame_tick_q;

    logic [N_DIGITS-1:0]   an_d;
    logic [6:0]            seg_d;
    logic                  dp_d;
    logic                  frame_tick_d;
    logic [3:0]            cur_nib;
    logic                  cur_dp;
    logic                  cur_blank;
    logic                  zero_run;
    logic                  lit;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] r;
        r = 7'h00;
        case (v)
            4'h0: r = 7'h3F;
            4'h1: r = 7'h06;
            4'h2: r = 7'h5B;
            4'h3: r = 7'h4F;
            4'h4: r = 7'h66;
            4'h5: r = 7'h6D;
            4'h6: r = 7'h7D;
            4'h7: r = 7'h07;
            4'h8: r = 7'h7F;
            4'h9: r = 7'h6F;
            4'hA: r = 7'h77;
            4'hB: r = 7'h7C;
            4'hC: r = 7'h39;
            4'hD: r = 7'h5E;
            4'hE: r = 7'h79;
            4'hF: r = 7'h71;
            default: r = 7'h00;
        endcase
        return r;
    endfunction

    // Scan from the top digit down so zero_run covers nibbles i..N_DIGITS-1.
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        zero_run  = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (snap_digits_q[4*i +: 4] == 4'h0);
            if (digit_idx_q == IDX_W'(i)) begin
                cur_nib   = snap_digits_q[4*i +: 4];
                cur_dp    = snap_dp_q[i];
                cur_blank = snap_lz_q && zero_run && (i != 0);
            end
        end

        lit  = (state_q == SHOW) && !cur_blank;
        an_d = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            an_d[i] = lit && (digit_idx_q == IDX_W'(i));
        end
        seg_d        = lit ? hex7(cur_nib) : 7'h00;
        dp_d         = lit && cur_dp;
        frame_tick_d = (state_q != IDLE) && (slot_cnt_q == '0) && (digit_idx_q == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            slot_cnt_q    <= '0;
            digit_idx_q   <= '0;
            snap_digits_q <= '0;
            snap_dp_q     <= '0;
            snap_lz_q     <= 1'b0;
            // NOTE: pin registers reset to the dark pattern, not to zero, so the
            // display is off while reset is held regardless of polarity.
            an_q          <= {N_DIGITS{POL}};
            seg_q         <= {7{POL}};
            dp_q          <= POL;
            frame_tick_q  <= 1'b0;
        end else begin
            an_q         <= an_d ^ {N_DIGITS{POL}};
            seg_q        <= seg_d ^ {7{POL}};
            dp_q         <= dp_d ^ POL;
            frame_tick_q <= frame_tick_d;

            if (!en) begin
                state_q     <= IDLE;
                slot_cnt_q  <= '0;
                digit_idx_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        snap_digits_q <= digits_in;
                        snap_dp_q     <= dp_in;
                        snap_lz_q     <= lz_suppress;
                        slot_cnt_q    <= '0;
                        digit_idx_q   <= '0;
                        state_q       <= SLOT_START;
                    end
                    BLANK: begin
                        slot_cnt_q <= slot_cnt_q + CNT_W'(1);
                        if (slot_cnt_q == CNT_W'(BLANK_LAST)) begin
                            state_q <= SHOW;
                        end
                    end
                    SHOW: begin
                        if (slot_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
                            slot_cnt_q <= '0;
                            state_q    <= SLOT_START;
                            if (digit_idx_q == IDX_W'(N_DIGITS - 1)) begin
                                // Frame wrap: take the tear-free snapshot for the next frame.
                                digit_idx_q   <= '0;
                                snap_digits_q <= digits_in;
                                snap_dp_q     <= dp_in;
                                snap_lz_q     <= lz_suppress;
                            end else begin
                                digit_idx_q <= digit_idx_q + IDX_W'(1);
                            end
                        end else begin
                            slot_cnt_q <= slot_cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q     <= IDLE;
                        slot_cnt_q  <= '0;
                        digit_idx_q <= '0;
                    end
                endcase
            end
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;
    assign digit_idx  = digit_idx_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: expected pin values per cycle are queued as
// each frame's inputs are driven and compared on the falling clock edge.
module tb_seg_scan_ctrl;

    localparam int N_DIGITS   = 4;
    localparam int SCAN_DIV   = 8;
    localparam int BLANK_CYC  = 2;
    localparam int ACTIVE_LOW = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        lz_suppress;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   n_out = 0;

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg_scan_ctrl #(
        .N_DIGITS  (N_DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC),
        .ACTIVE_LOW(ACTIVE_LOW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .lz_suppress(lz_suppress),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic push_off(input int n);
        exp_t e;
        e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, tick: 1'b0};
        for (int i = 0; i < n; i++) q.push_back(e);
    endtask

    // Expected pin stream of one frame: per digit, BLANK_CYC dark cycles then lit ones.
    task automatic push_frame(input logic [15:0] d, input logic [3:0] dpv, input logic lz,
                              input int n);
        exp_t       e;
        int         k;
        int         c;
        logic [3:0] nib;
        logic       supp;
        logic       lit;
        for (int j = 0; j < n; j++) begin
            k    = j / SCAN_DIV;
            c    = j % SCAN_DIV;
            nib  = d[4*k +: 4];
            supp = lz && (k > 0) && ((d >> (4*k)) == 16'h0);
            lit  = (c >= BLANK_CYC) && !supp;
            e.an   = lit ? 4'(~(4'b0001 << k)) : 4'hF;
            e.seg  = lit ? ~hex_tab[nib] : 7'h7F;
            e.dp   = lit ? ~dpv[k] : 1'b1;
            e.tick = (j == 0);
            q.push_back(e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check($sformatf("out%0d", n_out), {19'd0, an, seg, dp, frame_tick}, {19'd0, e});
            n_out++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        en          = 1'b0;
        digits_in   = 16'h0000;
        dp_in       = 4'h0;
        lz_suppress = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        check("rst_idx", digit_idx, 2'd0);
        check("rst_tick", frame_tick, 1'b0);
        rst = 1'b0;

        step(1);
        push_off(6);
        check("idle_idx", digit_idx, 2'd0);
        step(6);

        en = 1'b1; digits_in = 16'h1234; dp_in = 4'b0000; lz_suppress = 1'b0;
        push_off(2);
        push_frame(16'h1234, 4'b0000, 1'b0, 32);

        step(20);
        check("mid_idx", digit_idx, 2'd2);
        digits_in = 16'hABCD; dp_in = 4'b0101;
        push_frame(16'hABCD, 4'b0101, 1'b0, 32);

        step(32);
        digits_in = 16'h0050; dp_in = 4'b1000; lz_suppress = 1'b1;
        push_frame(16'h0050, 4'b1000, 1'b1, 32);

        step(32);
        digits_in = 16'h0000; dp_in = 4'b0000;
        push_frame(16'h0000, 4'b0000, 1'b1, 32);

        step(32);
        digits_in = 16'h9876; dp_in = 4'b0010; lz_suppress = 1'b0;
        push_frame(16'h9876, 4'b0010, 1'b0, 20);
        push_off(2);

        step(32);
        en = 1'b0;
        step(1);
        check("off_idx", digit_idx, 2'd0);

        step(3);
        en = 1'b1;
        push_off(2);
        push_frame(16'h9876, 4'b0010, 1'b0, 12);

        step(14);
        check("pre_rst_an", an, 4'b1101);
        #1 rst = 1'b1;
        #1;
        check("arst_an", an, 4'hF);
        check("arst_seg", seg, 7'h7F);
        check("arst_dp", dp, 1'b1);
        check("arst_idx", digit_idx, 2'd0);
        check("arst_tick", frame_tick, 1'b0);

        en = 1'b0;
        step(2);
        rst = 1'b0;
        step(2);
        check("drain", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for an N-digit common-anode/cathode 7-segment display.
- Consumes the counter's nibble outputs and sequences one digit at a time using an internal single-clock prescaler.
- Uses clock-enable ticks, not a derived clock, so the whole block stays in the clk domain.
- Inserts an anti-ghosting blank interval per slot, snapshots the input once per frame (tear-free), and optionally suppresses leading zeros.

Parameters:
- N_DIGITS, 4, number of digits scanned (2..8).
- SCAN_DIV, 50000, clk cycles per digit slot (>=2).
- BLANK_CYC, 500, cycles at start of each slot with all anodes off (0 <= BLANK_CYC < SCAN_DIV).
- ACTIVE_LOW, 1, 1 = an/seg/dp driven active-low, 0 = active-high.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  scan enable; low forces display dark and scan state to idle.
- digits_in  in  4*N_DIGITS  hex nibbles; nibble i = bits [4i+3:4i]; digit 0 = least significant.
- dp_in  in  N_DIGITS  decimal point per digit.
- lz_suppress  in  1  1 = blank leading zero digits.
- an  out  N_DIGITS  digit select, one-hot when lit.
- seg  out  7  segments; seg[0]=a ... seg[6]=g.
- dp  out  1  decimal point segment.
- digit_idx  out  clog2(N_DIGITS)  digit slot currently being scanned.
- frame_tick  out  1  one-cycle pulse at the start of each frame (digit 0 slot start).

Behaviour:
- State machine: IDLE, BLANK, SHOW; slot_cnt runs 0..SCAN_DIV-1.
- Reset (async): state IDLE, slot_cnt 0, digit_idx 0, frame_tick 0, snapshot 0. an/seg/dp are all "off": all 1s if ACTIVE_LOW, else all 0s.
- IDLE: outputs off, slot_cnt 0, digit_idx 0.
  - On a clk edge with en=1: snapshot digits_in/dp_in/lz_suppress, go to BLANK with slot_cnt 0, and pulse frame_tick in the following cycle.
- BLANK: all anodes off; slot_cnt increments each cycle.
  - When slot_cnt reaches BLANK_CYC-1, go to SHOW.
  - If BLANK_CYC=0, BLANK is skipped and the block enters SHOW directly.
- SHOW: an selects digit_idx; seg/dp show the decoded snapshot nibble.
- Slot end, slot_cnt==SCAN_DIV-1 in SHOW:
  - slot_cnt returns to 0 and digit_idx increments modulo N_DIGITS; state goes to BLANK (or SHOW if BLANK_CYC=0).
  - On wrap N_DIGITS-1 -> 0: re-snapshot inputs and set frame_tick=1 for exactly one cycle.
- en deasserted in any state: next edge returns to IDLE (outputs off). Mid-slot progress is discarded; re-enable restarts at digit 0.
- Output timing: an/seg/dp/frame_tick are registered, so the pins reflect the state/digit_idx of the previous cycle (1-cycle latency).
  - digit_idx is the state register itself, with no added latency.
- Hex decode, active-high segment bits g..a:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - ACTIVE_LOW inverts seg, an and dp.
- Leading-zero suppression (snapshot lz_suppress=1): digit i>0 is blanked if all snapshot nibbles i..N_DIGITS-1 are zero.
  - Blanking turns that digit's anode off for the whole slot, while the slot timing still runs.
  - Digit 0 is never suppressed.
  - dp_in of a suppressed digit is ignored.
- Inputs that change mid-frame have no visible effect until the next frame snapshot.

Test Plan (N_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, ACTIVE_LOW=1):
- Reset held, then released with en=0 -> an=1111, seg=7F, dp=1, digit_idx=0, frame_tick=0 indefinitely.
- en=1, digits_in=0x1234, dp_in=0 -> frame_tick pulses every 32 cycles. Each slot shows 2 cycles an=1111, then 6 cycles lit. Lit phases in order: an=1110/seg=~4F (3?) … precisely an=1110 seg=~66 ("4"), 1101 ~4F ("3"), 1011 ~5B ("2"), 0111 ~06 ("1").
- Change digits_in from 0x1234 to 0xABCD during digit 2 slot -> remaining slots of that frame still show 1234; the next frame shows d, C, b, A (seg ~5E, ~39, ~7C, ~77).
- lz_suppress=1, digits_in=0x0050 -> digits 3 and 2 show an=1111 for their full slots; digit 1 shows "5", digit 0 shows "0". digits_in=0x0000 -> only digit 0 lit, showing "0".
- Deassert en during a digit 2 SHOW phase -> next cycle state IDLE, one cycle later outputs off. Re-assert en -> restarts at digit_idx=0 with frame_tick pulse.
- Assert rst asynchronously mid-SHOW (between clk edges) -> outputs go off immediately without a clk edge, and digit_idx=0.
